// File: rtl/apb_mem_slave.sv
// APB word-addressed memory slave with byte strobes, programmable wait states
// and a slave-error response for misaligned or out-of-range addresses.
module apb_mem_slave #(
    parameter int unsigned          DATA_W      = 32,
    parameter int unsigned          ADDR_W      = 32,
    parameter int unsigned          DEPTH       = 1024,
    parameter logic [ADDR_W-1:0]    BASE_ADDR   = '0,
    parameter int unsigned          WAIT_STATES = 0
) (
    input  logic                  pclk,
    input  logic                  prst,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_W-1:0]     paddr,
    input  logic [DATA_W-1:0]     pwdata,
    input  logic [DATA_W/8-1:0]   pstrb,
    output logic [DATA_W-1:0]     prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic                wr_q;
    logic                err_q;
    logic [IDX_W-1:0]    idx_q;
    logic [DATA_W-1:0]   prdata_q;

    logic [ADDR_W-1:0]   offset;
    logic [ADDR_W-1:0]   idx_full;
    logic [IDX_W-1:0]    idx_d;
    logic                misalign;
    logic                err_d;
    logic                wr_en;

    logic [DATA_W-1:0]   mem [DEPTH];

    // Decode the address of the current setup cycle into a word index and error flag.
    assign offset   = paddr - BASE_ADDR;
    assign idx_full = offset >> OFF_W;
    assign idx_d    = idx_full[IDX_W-1:0];
    assign misalign = (paddr & ADDR_W'(STRB_W - 1)) != '0;
    assign err_d    = misalign || (paddr < BASE_ADDR) || (idx_full >= ADDR_W'(DEPTH));

    assign pready  = (state_q == ACCESS) && (cnt_q == 4'(WAIT_STATES));
    assign pslverr = pready & err_q;
    assign prdata  = prdata_q;
    assign wr_en   = (state_q == ACCESS) && psel && penable && pready && wr_q && !err_q;

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            idx_q    <= '0;
            prdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // penable without a preceding setup cycle is ignored
                    if (psel && !penable) begin
                        state_q <= ACCESS;
                        cnt_q   <= '0;
                        wr_q    <= pwrite;
                        err_q   <= err_d;
                        idx_q   <= idx_d;
                        if (!pwrite) begin
                            prdata_q <= err_d ? '0 : mem[idx_d];
                        end
                    end
                end
                ACCESS: begin
                    if (!psel) begin
                        state_q <= IDLE;
                    end else if (penable && pready) begin
                        state_q <= IDLE;
                    end else if (!pready) begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Storage is not reset; only lanes with a set strobe are written.
    always_ff @(posedge pclk) begin
        if (wr_en) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (pstrb[b]) begin
                    mem[idx_q][8*b +: 8] <= pwdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: doc/apb_mem_slave.md
# apb_mem_slave

Parametrised APB memory slave: a word-addressed storage array on an APB bus with configurable data width, depth, base address and wait states, plus byte-lane write strobes and a slave-error response for misaligned or out-of-range accesses. Used as a scratch memory and register-bank model behind the APB interconnect. Read data is registered at the end of the setup phase, so the array maps onto synchronous block RAM.

## Interface
- DATA_W, 32: data bus width in bits; must be 8, 16, 32 or 64.
- ADDR_W, 32: byte-address width.
- DEPTH, 1024: number of DATA_W-bit words.
- BASE_ADDR, 0: byte address of word 0; must be DATA_W/8 aligned.
- WAIT_STATES, 0: access-phase cycles with pready low before completion; 0..15.

- pclk  in  1  clock; all logic on rising edge.
- prst  in  1  reset; asynchronous, active-high.
- psel  in  1  slave select.
- penable  in  1  access-phase indicator.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_W  byte address.
- pwdata  in  DATA_W  write data.
- pstrb  in  DATA_W/8  write byte-lane enables; bit i gates pwdata[8i+7:8i].
- prdata  out  DATA_W  read data.
- pready  out  1  transfer completion.
- pslverr  out  1  error flag; valid only when pready=1.

## Operation
- FSM has two states, IDLE and ACCESS; reset state is IDLE.
- IDLE: psel=1 and penable=0 is a setup cycle. On that edge:
  - go to ACCESS and clear wait counter cnt (4 bits);
  - latch pwrite and the word index idx = (paddr - BASE_ADDR) >> log2(DATA_W/8);
  - latch err = (paddr low log2(DATA_W/8) bits != 0) or (paddr < BASE_ADDR) or (idx >= DEPTH);
  - if read: prdata <= err ? 0 : mem[idx].
- IDLE with penable=1 and no prior setup is a protocol violation. It is ignored: no state change, pready=0.
- ACCESS: pready = (cnt == WAIT_STATES).
  - While pready=0 and psel=1, cnt increments each cycle.
  - When psel=1, penable=1 and pready=1, the transfer completes: return to IDLE.
  - If it is a write and err=0, update mem[idx] on that edge, only in lanes with pstrb=1.
- psel=0 while in ACCESS aborts the transfer: return to IDLE, no write, prdata keeps its value.
- pslverr = pready & err. An errored write leaves memory unchanged; an errored read returns 0.
- pstrb=0 on a write completes normally with no memory change and no error. pstrb is ignored on reads.
- prdata holds its last loaded value until the next read setup cycle. It is not changed by writes, including a write to the same word.
- Memory contents are undefined at power-up and are not cleared by prst. Only control state and outputs are reset.

## Timing
- Reset values: prdata=0, pready=0, pslverr=0, state IDLE, cnt=0.
- pready and pslverr are combinational from state, cnt and the latched err. They are 0 whenever the FSM is in IDLE.
- Transfer length is 2 + WAIT_STATES cycles: one setup cycle plus access cycles. With WAIT_STATES=0, pready=1 in the first access cycle.
- Back-to-back transfers: a new setup cycle may follow immediately after a completing access cycle, with no idle cycle between.
- A write becomes visible to a read whose setup cycle falls on or after the write's completion edge.
- prst asserted mid-transfer: the FSM goes to IDLE immediately, any pending write is dropped, outputs take their reset values, and memory is untouched.

## Test plan
- DATA_W=32, WAIT_STATES=0: write 0xDEADBEEF to 0x10 with pstrb=0xF, then read 0x10 -> 2-cycle transfers, pready=1 in the access cycle, prdata=0xDEADBEEF, pslverr=0.
- WAIT_STATES=3: read 0x10 -> pready low for 3 access cycles and high on the 4th; prdata is valid from the first access cycle.
- Byte strobes: with 0xDEADBEEF stored at 0x10, write 0x11223344 with pstrb=0b0101 -> a later read returns 0xDE22BE44.
- Errors: read 0x11 (misaligned) and read 4*DEPTH (out of range) -> pready=1, pslverr=1, prdata=0. A write to 4*DEPTH leaves all words unchanged.
- Abort and reset: drop psel during a write in the 2nd wait cycle -> no memory change. Assert prst during a write access -> pready=0, prdata=0, and the word retains its old value.
- Back-to-back: write 0x1 to 0x20, then read 0x20 in the immediately following setup cycle -> prdata=0x1.
